// File: rtl/scpu_ifetch.sv
// Instruction-fetch stage for the single-cycle CPU.
// Holds the PC, fetches one word per instruction over a ready handshake,
// presents the instruction register (with OPcode/Fun fields) to the
// controller, and advances the PC (sequential, branch or jump) on ex_done.
//
// Optional feature macro: IFETCH_TIMEOUT_EN
//   defined   -> REQ wait cycles are counted; reaching TIMEOUT enters a sticky
//                ERR state (fetch_err=1) that only reset leaves.
//   undefined -> REQ waits indefinitely; fetch_err is tied low.
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | one idle cycle after reset before the first request
// REQ   | imem_req high, waiting for imem_ready to capture the word
// HOLD  | IR valid, waiting for ex_done to advance the PC
// ERR   | fetch timed out (IFETCH_TIMEOUT_EN only); left only by reset

module scpu_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst_out,
  output logic [5:0]  OPcode,
  output logic [5:0]  Fun,
  output logic        inst_valid,
  output logic [31:0] pc_out,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  input  logic        ex_done,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
`ifdef IFETCH_TIMEOUT_EN
    , S_ERR = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  logic          err_q;
`endif

  // Next-PC selection; only consumed on the ex_done edge in HOLD.
  always_comb begin
    pc4    = pc + 32'd4;
    br_off = {{14{ir[15]}}, ir[15:0], 2'b00};
    if (Jump)
      next_pc = {pc4[31:28], ir[25:0], 2'b00};
    else if (Branch && zero)
      next_pc = pc4 + br_off;
    else
      next_pc = pc4;
  end

  // Fetch FSM with registered request/valid flags, PC and IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_BOOT;
      pc      <= RESET_PC;
      ir      <= 32'h0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      cnt     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          if (imem_ready) begin
            ir      <= imem_rdata;
            state   <= S_HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            state <= S_ERR;
            req_q <= 1'b0;
            err_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        S_HOLD: begin
          if (ex_done) begin
            pc      <= next_pc;
            state   <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
`ifdef IFETCH_TIMEOUT_EN
        S_ERR: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end
`endif
        default: begin
          state   <= S_BOOT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign inst_out   = ir;
  assign OPcode     = ir[31:26];
  assign Fun        = ir[5:0];
  assign inst_valid = valid_q;

`ifdef IFETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_scpu_ifetch.sv
// Scoreboard bench for scpu_ifetch: a driver walks a table of directed
// instruction vectors acting as memory and execute stage, pushing the
// expected fetch (PC, word, latency) into a queue; a monitor pops and
// compares whenever inst_valid rises.
module tb_scpu_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] inst_out;
  logic [5:0]  OPcode;
  logic [5:0]  Fun;
  logic        inst_valid;
  logic [31:0] pc_out;
  logic        Branch;
  logic        Jump;
  logic        zero;
  logic        ex_done;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  scpu_ifetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .inst_out(inst_out), .OPcode(OPcode), .Fun(Fun),
    .inst_valid(inst_valid), .pc_out(pc_out),
    .Branch(Branch), .Jump(Jump), .zero(zero),
    .ex_done(ex_done), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [7:0]  lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] pc;     // expected fetch address
    logic [31:0] data;   // word returned by memory
    int          waits;  // REQ cycles with imem_ready low
    int          hold;   // HOLD cycles before ex_done
    logic        br, jp, z;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  // Monitor: pops one expectation per rising inst_valid.
  logic iv_q = 1'b0, req_q = 1'b0;
  int   req_start = 0;
  always @(negedge clk) begin
    if (imem_req && !req_q) req_start = cyc;
    if (inst_valid && !iv_q) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        logic [31:0] d;
        e = sb.pop_front();
        d = e.data;
        chk("mon_pc", pc_out, e.pc);
        chk("mon_inst", inst_out, d);
        chk("mon_opcode", {26'd0, OPcode}, {26'd0, d[31:26]});
        chk("mon_fun", {26'd0, Fun}, {26'd0, d[5:0]});
        chk("mon_latency", cyc - req_start, {24'd0, e.lat});
      end
    end
    req_q = imem_req;
    iv_q  = inst_valid;
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h1000_FFFE, 3, 0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0004, 32'h0000_0020, 0, 2, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0008, 32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_000C, 32'h1000_FFFF, 1, 0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_000C, 32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h0FFF_FFFC, 32'h0800_0000, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'h1000_0000, 32'h0800_0010, 0, 1, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{32'h1000_0040, 32'h0000_0020, 2, 0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    Branch = 1'b0; Jump = 1'b0; zero = 1'b0; ex_done = 1'b0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst_out, 32'h0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);

    foreach (vecs[i]) begin
      wait_req();
      chk("fetch_addr", imem_addr, vecs[i].pc);
      sb.push_back('{vecs[i].pc, vecs[i].data, 8'(vecs[i].waits + 1)});
      // Wait states with ignored ex_done/Jump noise
      imem_ready = 1'b0; ex_done = 1'b1; Jump = 1'b1;
      repeat (vecs[i].waits) begin
        @(negedge clk);
        chk("wait_addr", imem_addr, vecs[i].pc);
        chk("wait_req", {31'd0, imem_req}, 32'd1);
      end
      ex_done = 1'b0; Jump = 1'b0;
      imem_ready = 1'b1; imem_rdata = vecs[i].data;
      @(negedge clk);
      // HOLD with ignored imem_ready/junk data
      imem_rdata = 32'hDEAD_BEEF;
      repeat (vecs[i].hold) @(negedge clk);
      imem_ready = 1'b0;
      chk("hold_inst", inst_out, vecs[i].data);
      ex_done = 1'b1; Branch = vecs[i].br; Jump = vecs[i].jp; zero = vecs[i].z;
      @(negedge clk);
      ex_done = 1'b0; Branch = 1'b0; Jump = 1'b0; zero = 1'b0;
    end
    wait_req();
    chk("final_addr", imem_addr, 32'h1000_0044);

    // Reset during REQ takes effect immediately
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    wait_req();
    chk("restart_addr", imem_addr, 32'h0);

`ifdef IFETCH_TIMEOUT_EN
    begin
      int start;
      int n;
      start = cyc;
      n = 0;
      while (fetch_err !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("to_err", {31'd0, fetch_err}, 32'd1);
      chk("to_cycles", cyc - start, 32'd16);
      chk("to_req", {31'd0, imem_req}, 32'd0);
      imem_ready = 1'b1;
      @(negedge clk);
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      chk("err_req", {31'd0, imem_req}, 32'd0);
      chk("err_valid", {31'd0, inst_valid}, 32'd0);
      imem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("err_clear", {31'd0, fetch_err}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      wait_req();
      chk("err_restart", imem_addr, 32'h0);
    end
`else
    repeat (30) @(negedge clk);
    chk("no_err", {31'd0, fetch_err}, 32'd0);
    chk("wait_forever", {31'd0, imem_req}, 32'd1);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
